pellet_ctrl: RTL and testbench

PELLET_CTRL -- requirements
Module: pellet_ctrl

---
 rtl/pacman_pkg.sv | 23 ++
 rtl/pellet_ram.sv | 31 +++
 rtl/pellet_ctrl.sv | 157 +++++++++++++++
 tb/tb_pellet_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared constants, FSM state type and score helper for the pellet map controller.
package pacman_pkg;

   localparam int NUM_CELLS     = 1200;
   localparam int CELL_W        = 11;
   localparam int PELLET_POINTS = 10;

   localparam logic [CELL_W-1:0] NUM_CELLS_W = CELL_W'(NUM_CELLS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_EAT_RD,
      S_EAT_WR
   } state_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/pellet_ram.sv
// 1200x1 pellet map: port A synchronous read-only, port B synchronous read/write.
// Port A returns the old contents when port B writes the same cell in the same cycle.
module pellet_ram
   import pacman_pkg::*;
(
   input  logic              Clk,
   input  logic [CELL_W-1:0] i_addr_a,
   output logic              o_dout_a,
   input  logic [CELL_W-1:0] i_addr_b,
   input  logic              i_we_b,
   input  logic              i_din_b,
   output logic              o_dout_b
);

   logic r_mem [0:NUM_CELLS-1];
   logic r_dout_a;
   logic r_dout_b;

   // Out-of-range addresses read as empty cells and never write.
   always_ff @(posedge Clk) begin
      if (i_we_b && (i_addr_b < NUM_CELLS_W)) begin
         r_mem[i_addr_b] <= i_din_b;
      end
      r_dout_a <= (i_addr_a < NUM_CELLS_W) ? r_mem[i_addr_a] : 1'b0;
      r_dout_b <= (i_addr_b < NUM_CELLS_W) ? r_mem[i_addr_b] : 1'b0;
   end

   assign o_dout_a = r_dout_a;
   assign o_dout_b = r_dout_b;

endmodule

// File: rtl/pellet_ctrl.sv
// Pellet map controller: refills the map from a layout ROM and services eat requests.
// Optional PELLET_SCORE_EN adds a saturating 16-bit score output.
module pellet_ctrl
   import pacman_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start_level,
   input  logic [10:0] disp_index,
   output logic        disp_pellet,
   input  logic        eat_valid,
   input  logic [10:0] eat_index,
   output logic        eat_ready,
   output logic        eaten,
   output logic [10:0] rom_addr,
   input  logic        rom_bit,
   output logic        busy,
   output logic [10:0] pellets_left,
   output logic        level_clear
`ifdef PELLET_SCORE_EN
   ,
   output logic [15:0] score
`endif
);

   state_t      r_state, w_state_nxt;
   logic [10:0] r_fill_cnt, w_fill_cnt_nxt;
   logic [10:0] r_pellets, w_pellets_nxt;
   logic [10:0] r_eat_idx, w_eat_idx_nxt;
   logic        r_filled, w_filled_nxt;
   logic        r_level_clear;
   logic [10:0] w_addr_b;
   logic        w_we_b;
   logic        w_din_b;
   logic        w_eaten;
   logic        w_dout_a;
   logic        w_dout_b;

   pellet_ram u_ram (
      .Clk      (Clk),
      .i_addr_a (disp_index),
      .o_dout_a (w_dout_a),
      .i_addr_b (w_addr_b),
      .i_we_b   (w_we_b),
      .i_din_b  (w_din_b),
      .o_dout_b (w_dout_b)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state       <= S_IDLE;
         r_fill_cnt    <= '0;
         r_pellets     <= '0;
         r_filled      <= 1'b0;
         r_level_clear <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_fill_cnt    <= w_fill_cnt_nxt;
         r_pellets     <= w_pellets_nxt;
         r_filled      <= w_filled_nxt;
         r_level_clear <= w_filled_nxt && (w_pellets_nxt == '0) && (w_state_nxt == S_IDLE);
      end
   end

   always_ff @(posedge Clk) begin
      r_eat_idx <= w_eat_idx_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_fill_cnt_nxt = r_fill_cnt;
      w_pellets_nxt  = r_pellets;
      w_filled_nxt   = r_filled;
      w_eat_idx_nxt  = r_eat_idx;
      w_addr_b       = r_eat_idx;
      w_we_b         = 1'b0;
      w_din_b        = 1'b0;
      w_eaten        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (eat_valid) begin
               w_eat_idx_nxt = eat_index;
               w_state_nxt   = S_EAT_RD;
            end
         end
         S_FILL: begin
            // ROM data lags the address by one cycle, so cycle k writes cell k-1.
            if (r_fill_cnt != '0) begin
               w_addr_b = r_fill_cnt - 11'd1;
               w_we_b   = 1'b1;
               w_din_b  = rom_bit;
               if (rom_bit) begin
                  w_pellets_nxt = r_pellets + 11'd1;
               end
            end
            if (r_fill_cnt == NUM_CELLS_W) begin
               w_state_nxt  = S_IDLE;
               w_filled_nxt = 1'b1;
            end else begin
               w_fill_cnt_nxt = r_fill_cnt + 11'd1;
            end
         end
         S_EAT_RD: begin
            w_state_nxt = S_EAT_WR;
         end
         S_EAT_WR: begin
            w_state_nxt = S_IDLE;
            if (r_filled && w_dout_b && (r_eat_idx < NUM_CELLS_W) && (r_pellets != '0)) begin
               w_we_b        = 1'b1;
               w_eaten       = 1'b1;
               w_pellets_nxt = r_pellets - 11'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // A new level abandons whatever was in flight, including an eat about to write.
      if (start_level) begin
         w_state_nxt    = S_FILL;
         w_fill_cnt_nxt = '0;
         w_pellets_nxt  = '0;
         w_filled_nxt   = 1'b0;
         w_we_b         = 1'b0;
         w_eaten        = 1'b0;
      end
      if (Reset) begin
         w_we_b  = 1'b0;
         w_eaten = 1'b0;
      end
   end

   assign rom_addr     = ((r_state == S_FILL) && (r_fill_cnt < NUM_CELLS_W)) ? r_fill_cnt : '0;
   assign busy         = (r_state == S_FILL);
   assign eat_ready    = (r_state == S_IDLE);
   assign eaten        = w_eaten;
   assign disp_pellet  = w_dout_a & r_filled;
   assign pellets_left = r_pellets;
   assign level_clear  = r_level_clear;

`ifdef PELLET_SCORE_EN
   logic [15:0] r_score;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_score <= '0;
      end else if (w_eaten) begin
         r_score <= sat_add16(r_score, 16'(PELLET_POINTS));
      end
   end

   assign score = r_score;
`endif

endmodule

// File: tb/tb_pellet_ctrl.sv
// Self-checking bench for pellet_ctrl: directed level/eat scenarios plus randomized layouts
// and eats, compared against a cell-array reference model.
module tb_pellet_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        start_level;
   logic [10:0] disp_index;
   logic        disp_pellet;
   logic        eat_valid;
   logic [10:0] eat_index;
   logic        eat_ready;
   logic        eaten;
   logic [10:0] rom_addr;
   logic        rom_bit = 1'b0;
   logic        busy;
   logic [10:0] pellets_left;
   logic        level_clear;
`ifdef PELLET_SCORE_EN
   logic [15:0] score;
`endif

   bit rom_mem [0:1199];
   bit mdl_map [0:1199];
   int mdl_left;
   bit mdl_filled;
   int mdl_score;
   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   always @(posedge Clk) rom_bit <= (rom_addr < 11'd1200) ? rom_mem[rom_addr] : 1'b0;

   pellet_ctrl dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .start_level  (start_level),
      .disp_index   (disp_index),
      .disp_pellet  (disp_pellet),
      .eat_valid    (eat_valid),
      .eat_index    (eat_index),
      .eat_ready    (eat_ready),
      .eaten        (eaten),
      .rom_addr     (rom_addr),
      .rom_bit      (rom_bit),
      .busy         (busy),
      .pellets_left (pellets_left),
      .level_clear  (level_clear)
`ifdef PELLET_SCORE_EN
      ,
      .score        (score)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_bit(input int idx);
      if (!mdl_filled || idx < 0 || idx >= 1200) return 1'b0;
      return mdl_map[idx];
   endfunction

   function automatic int find_pellet();
      int start;
      start = $urandom_range(1199);
      for (int k = 0; k < 1200; k++) begin
         if (mdl_map[(start + k) % 1200]) return (start + k) % 1200;
      end
      return -1;
   endfunction

   // After a complete fill the map is the ROM image and the count is its population.
   task automatic load_model();
      mdl_left = 0;
      foreach (rom_mem[i]) begin
         mdl_map[i] = rom_mem[i];
         mdl_left += int'(rom_mem[i]);
      end
      mdl_filled = 1'b1;
   endtask

   task automatic wait_fill_done(input string tag, input int expected_len);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 1400) begin
         n++;
         @(negedge Clk);
      end
      check({tag, "_busy_len"}, n, expected_len);
      load_model();
      check({tag, "_pellets"}, pellets_left, mdl_left);
      check({tag, "_lvl_clr"}, level_clear, (mdl_left == 0));
`ifdef PELLET_SCORE_EN
      check({tag, "_score"}, score, mdl_score);
`endif
   endtask

   task automatic fill(input string tag);
      @(negedge Clk);
      start_level = 1'b1;
      @(negedge Clk);
      start_level = 1'b0;
      mdl_filled = 1'b0;
      check({tag, "_lvl_clr_drop"}, level_clear, 0);
      check({tag, "_rom_addr0"}, rom_addr, 0);
      wait_fill_done(tag, 1201);
   endtask

   task automatic check_disp(input string tag, input int idx);
      disp_index = 11'(idx);
      @(negedge Clk);
      check(tag, disp_pellet, model_bit(idx));
   endtask

   task automatic eat(input string tag, input int idx);
      bit old_bit, hit;
      old_bit = model_bit(idx);
      hit = old_bit && (mdl_left > 0);
      check({tag, "_ready_idle"}, eat_ready, 1);
      eat_valid  = 1'b1;
      eat_index  = 11'(idx);
      disp_index = 11'(idx);
      @(negedge Clk);
      eat_index = 11'($urandom);
      check({tag, "_ready_rd"}, eat_ready, 0);
      check({tag, "_eaten_rd"}, eaten, 0);
      @(negedge Clk);
      check({tag, "_ready_wr"}, eat_ready, 0);
      check({tag, "_eaten_wr"}, eaten, hit);
      if (hit) begin
         mdl_map[idx] = 1'b0;
         mdl_left--;
         mdl_score = (mdl_score + 10 > 65535) ? 65535 : mdl_score + 10;
      end
      @(negedge Clk);
      eat_valid = 1'b0;
      check({tag, "_ready_back"}, eat_ready, 1);
      check({tag, "_eaten_back"}, eaten, 0);
      check({tag, "_pellets"}, pellets_left, mdl_left);
      check({tag, "_lvl_clr"}, level_clear, (mdl_filled && mdl_left == 0));
      check({tag, "_disp_old"}, disp_pellet, old_bit);
`ifdef PELLET_SCORE_EN
      check({tag, "_score"}, score, mdl_score);
`endif
      @(negedge Clk);
      check({tag, "_disp_new"}, disp_pellet, model_bit(idx));
   endtask

   initial begin
      int p;
      Reset       = 1'b1;
      start_level = 1'b0;
      disp_index  = '0;
      eat_valid   = 1'b0;
      eat_index   = '0;
      mdl_filled  = 1'b0;
      mdl_left    = 0;
      mdl_score   = 0;
      foreach (rom_mem[i]) rom_mem[i] = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_busy", busy, 0);
      check("rst_eaten", eaten, 0);
      check("rst_disp", disp_pellet, 0);
      check("rst_lvl_clr", level_clear, 0);
      check("rst_pellets", pellets_left, 0);
      check("rst_ready", eat_ready, 1);
      check("rst_rom_addr", rom_addr, 0);
`ifdef PELLET_SCORE_EN
      check("rst_score", score, 0);
`endif
      Reset = 1'b0;

      // Three-pellet layout and the directed eat sequence on it.
      rom_mem[0] = 1'b1;
      rom_mem[41] = 1'b1;
      rom_mem[1199] = 1'b1;
      fill("fill3");
      check("fill3_count", pellets_left, 3);
      check_disp("disp41", 41);
      check_disp("disp40", 40);
      check_disp("disp1199", 1199);
      eat("eat41", 41);
      check("after41_pellets", pellets_left, 2);
      eat("eat41_again", 41);
      eat("eat1500", 1500);
      eat("eat0", 0);
      eat("eat1199", 1199);
      check("all_eaten_clear", level_clear, 1);
`ifdef PELLET_SCORE_EN
      check("score_30", score, 30);
`endif

      // Random layouts and random eats.
      for (int r = 0; r < 2; r++) begin
         foreach (rom_mem[i]) rom_mem[i] = ($urandom_range(3) == 0);
         fill("fill_rand");
         for (int e = 0; e < 30; e++) begin
            p = find_pellet();
            if (p < 0 || $urandom_range(3) == 0) p = $urandom_range(2047);
            eat("eat_rand", p);
         end
         for (int d = 0; d < 10; d++) check_disp("disp_rand", $urandom_range(1199));
      end

      // start_level while an eat is in its read cycle.
      p = find_pellet();
      if (p < 0) p = 5;
      @(negedge Clk);
      eat_valid = 1'b1;
      eat_index = 11'(p);
      @(negedge Clk);
      eat_valid = 1'b0;
      start_level = 1'b1;
      check("abort_eaten_rd", eaten, 0);
      @(negedge Clk);
      start_level = 1'b0;
      mdl_filled = 1'b0;
      check("abort_eaten_fill", eaten, 0);
      check("abort_busy", busy, 1);
      check("abort_rom_addr0", rom_addr, 0);
      check("abort_pellets0", pellets_left, 0);
      check("abort_disp", disp_pellet, 0);
      @(negedge Clk);
      check("abort_rom_addr1", rom_addr, 1);
      check("abort_eaten_next", eaten, 0);
      wait_fill_done("refill", 1200);

      // Reset mid-fill, asserted together with start_level.
      @(negedge Clk);
      start_level = 1'b1;
      @(negedge Clk);
      start_level = 1'b0;
      repeat (500) @(negedge Clk);
      Reset = 1'b1;
      start_level = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      start_level = 1'b0;
      mdl_filled = 1'b0;
      mdl_left = 0;
      mdl_score = 0;
      check("midrst_busy", busy, 0);
      check("midrst_pellets", pellets_left, 0);
      check("midrst_lvl_clr", level_clear, 0);
      check("midrst_eaten", eaten, 0);
      check("midrst_disp", disp_pellet, 0);
      check("midrst_rom_addr", rom_addr, 0);
      check("midrst_ready", eat_ready, 1);
      check_disp("midrst_disp41", 41);
      eat("eat_unfilled", 41);
      fill("fill_after_rst");

`ifdef PELLET_SCORE_EN
      foreach (rom_mem[i]) rom_mem[i] = 1'b1;
      for (int f = 0; f < 6; f++) begin
         fill("fill_ones");
         for (int i = 0; i < 1200; i++) eat("eat_sat", i);
      end
      check("score_sat", score, 65535);
      fill("fill_keep_score");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
